// File: rtl/core_config.sv
// rtl/core_config.sv - shared bus widths for the read-path blocks
package core_config;
    localparam int ADDR_WIDTH     = 32;
    localparam int AXI_DATA_WIDTH = 64;
endpackage

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - round-robin AR arbiter with per-master outstanding limit and R broadcast
// Optional registered R stage: define AXI_RD_ARB_RREG_EN.
module axi_read_arbiter
    import core_config::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          m_arvalid,
    output logic [NUM_MASTERS-1:0]          m_arready,
    input  logic [NUM_MASTERS*8-1:0]        m_arid,
    input  logic [NUM_MASTERS*8-1:0]        m_arlen,
    input  logic [NUM_MASTERS*2-1:0]        m_arburst,
    input  logic [NUM_MASTERS*3-1:0]        m_arsize,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
    input  logic [NUM_MASTERS*4-1:0]        m_arcache,
    output logic                            s_arvalid,
    input  logic                            s_arready,
    output logic [7:0]                      s_arid,
    output logic [7:0]                      s_arlen,
    output logic [1:0]                      s_arburst,
    output logic [2:0]                      s_arsize,
    output logic [ADDR_WIDTH-1:0]           s_araddr,
    output logic [3:0]                      s_arcache,
    input  logic                            s_rvalid,
    input  logic                            s_rlast,
    input  logic [7:0]                      s_rid,
    input  logic [AXI_DATA_WIDTH-1:0]       s_rdata,
    input  logic [1:0]                      s_rresp,
    output logic                            s_rready,
    output logic                            m_rvalid,
    output logic                            m_rlast,
    output logic [7:0]                      m_rid,
    output logic [AXI_DATA_WIDTH-1:0]       m_rdata,
    output logic [1:0]                      m_rresp,
    output logic                            rid_err
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state, state_next;
    logic [GW-1:0]          grant, last_grant, pick;
    logic [GW:0]            rr_sum;
    logic                   found;
    logic                   ar_done;
    logic [NUM_MASTERS-1:0] eligible, inc, dec;
    logic [CW-1:0]          outstanding [NUM_MASTERS];
    logic                   r_valid, r_last, r_known, err_hit;
    logic [7:0]             r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]             r_resp;

    // Round-robin search starting just after the last master that completed an issue
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_sum = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            eligible[i] = m_arvalid[i] && (outstanding[i] < CW'(MAX_OUTSTANDING));
        end
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            rr_sum = {1'b0, last_grant} + (GW+1)'(k);
            if (rr_sum >= (GW+1)'(NUM_MASTERS)) begin
                rr_sum = rr_sum - (GW+1)'(NUM_MASTERS);
            end
            if (!found && eligible[rr_sum[GW-1:0]]) begin
                found = 1'b1;
                pick  = rr_sum[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        m_arready  = '0;
        unique case (state)
            IDLE: begin
                if (found && rst) begin
                    m_arready[pick] = 1'b1;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                if (s_arready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s_arvalid = (state == ISSUE);
    assign ar_done   = (state == ISSUE) && s_arready;
    assign s_rready  = 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
            s_arid     <= '0;
            s_arlen    <= '0;
            s_arburst  <= '0;
            s_arsize   <= '0;
            s_araddr   <= '0;
            s_arcache  <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant     <= pick;
                s_arid    <= m_arid[int'(pick)*8 +: 8];
                s_arlen   <= m_arlen[int'(pick)*8 +: 8];
                s_arburst <= m_arburst[int'(pick)*2 +: 2];
                s_arsize  <= m_arsize[int'(pick)*3 +: 3];
                s_araddr  <= m_araddr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                s_arcache <= m_arcache[int'(pick)*4 +: 4];
            end
            if (ar_done) begin
                last_grant <= grant;
            end
        end
    end

`ifdef AXI_RD_ARB_RREG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
            r_resp  <= '0;
        end else begin
            r_valid <= s_rvalid;
            r_last  <= s_rlast;
            r_id    <= s_rid;
            r_data  <= s_rdata;
            r_resp  <= s_rresp;
        end
    end
`else
    always_comb begin
        r_valid = rst && s_rvalid;
        r_last  = rst && s_rlast;
        r_id    = rst ? s_rid   : '0;
        r_data  = rst ? s_rdata : '0;
        r_resp  = rst ? s_rresp : '0;
    end
`endif

    assign m_rvalid = r_valid;
    assign m_rlast  = r_last;
    assign m_rid    = r_id;
    assign m_rdata  = r_data;
    assign m_rresp  = r_resp;

    // Counters follow the beat as seen on the master-side R bus
    always_comb begin
        r_known = (r_id < 8'(NUM_MASTERS));
        err_hit = r_valid && !r_known;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            inc[i] = ar_done && (grant == GW'(i));
            dec[i] = r_valid && r_last && r_known && (r_id == 8'(i));
            if (dec[i] && (outstanding[i] == '0)) begin
                err_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                outstanding[i] <= '0;
            end
            rid_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (inc[i] && !dec[i]) begin
                    outstanding[i] <= outstanding[i] + 1'b1;
                end else if (dec[i] && !inc[i] && (outstanding[i] != '0)) begin
                    outstanding[i] <= outstanding[i] - 1'b1;
                end
            end
            if (err_hit) begin
                rid_err <= 1'b1;
            end
        end
    end
endmodule
